mmio_bus_fabric: RTL

- Parametrised successor to the CPU-side memory chip-select/readback path.
- Takes one processor load/store request and decodes it into one of N_SLV equal power-of-two regions (RAM, image ROM, peripherals, ...).
- Drives a held request/acknowledge handshake to the selected slave and returns registered read data with a completion pulse.
- Adds three things a plain combinational decoder lacks: variable slave latency, unmapped-address error and timeout error.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_bus_fabric_if.sv | 35 +++
 rtl/mmio_region_decode.sv | 22 ++
 rtl/mmio_bus_fabric.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and helpers for the MMIO fabric: FSM states, default geometry and region decode.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_REGION_SHIFT = 14;
  localparam int DEF_TIMEOUT      = 15;

  // Keeps every upper address bit so out-of-range regions never alias onto low slaves.
  function automatic logic [63:0] region_idx(input logic [63:0] addr, input int shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/mmio_bus_fabric_if.sv
// Processor-side request/response bus plus slave-side held request/ack bus of the MMIO fabric.
// slave: the fabric's view; master: the processor + slave-device environment view.
interface mmio_bus_fabric_if
  import mmio_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int N_SLV        = 4,
  parameter int REGION_SHIFT = DEF_REGION_SHIFT
);
  logic                    m_req;
  logic                    m_we;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_ready;
  logic                    m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_err;
  logic [N_SLV-1:0]        s_req;
  logic                    s_we;
  logic [REGION_SHIFT-1:0] s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV-1:0]        s_ack;
  logic [N_SLV*DATA_W-1:0] s_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
    output m_ready, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmio_region_decode.sv
// Combinational address decode into region index, mapped flag and local offset.
// Latency: 0 cycles; backpressure: none (pure function of the address).
module mmio_region_decode
  import mmio_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int N_SLV        = 4,
  parameter int REGION_SHIFT = DEF_REGION_SHIFT,
  parameter int IDX_W        = $clog2(N_SLV)
) (
  input  logic [ADDR_W-1:0]       addr,
  output logic [IDX_W-1:0]        idx,
  output logic                    mapped,
  output logic [REGION_SHIFT-1:0] offset
);
  logic [63:0] full_idx;

  assign full_idx = region_idx(64'(addr), REGION_SHIFT);
  assign mapped   = (full_idx < 64'(N_SLV));
  assign idx      = full_idx[IDX_W-1:0];
  assign offset   = addr[REGION_SHIFT-1:0];
endmodule

// File: rtl/mmio_bus_fabric.sv
// Decodes one processor access onto N_SLV held req/ack slaves; unmapped/timeout report m_err.
// Latency: unmapped 1, ack delay d -> d+2, timeout TIMEOUT+1; m_ready low from accept to response.
module mmio_bus_fabric
  import mmio_pkg::*;
#(
  parameter int               ADDR_W       = 32,
  parameter int               DATA_W       = 32,
  parameter int               N_SLV        = 4,
  parameter int               REGION_SHIFT = DEF_REGION_SHIFT,
  parameter int               TIMEOUT      = DEF_TIMEOUT,
  parameter logic [N_SLV-1:0] NARROW_MASK  = {{(N_SLV-1){1'b0}}, 1'b1}
) (
  input logic          clk,
  input logic          rst,
  mmio_bus_fabric_if.slave bus
);
  localparam int IDX_W = $clog2(N_SLV);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [N_SLV-1:0] ONE_HOT0 = {{(N_SLV-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt;
  logic [N_SLV-1:0]        req_q;
  logic                    we_q;
  logic [REGION_SHIFT-1:0] addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    rvalid_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;

  logic [IDX_W-1:0]        dec_idx;
  logic                    dec_mapped;
  logic [REGION_SHIFT-1:0] dec_offset;
  logic                    ack_sel;
  logic [DATA_W-1:0]       sel_rdata;
  logic [DATA_W-1:0]       cap_rdata;

  mmio_region_decode #(
    .ADDR_W      (ADDR_W),
    .N_SLV       (N_SLV),
    .REGION_SHIFT(REGION_SHIFT),
    .IDX_W       (IDX_W)
  ) u_decode (
    .addr  (bus.m_addr),
    .idx   (dec_idx),
    .mapped(dec_mapped),
    .offset(dec_offset)
  );

  // Only the latched slave's ack and data lane are ever looked at.
  assign ack_sel   = bus.s_ack[idx_q];
  assign sel_rdata = bus.s_rdata[int'(idx_q)*DATA_W +: DATA_W];
  assign cap_rdata = we_q ? '0 :
                     NARROW_MASK[idx_q] ? {{(DATA_W-8){1'b0}}, sel_rdata[7:0]} : sel_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      cnt      <= '0;
      req_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_req) begin
            we_q    <= bus.m_we;
            addr_q  <= dec_offset;
            wdata_q <= bus.m_wdata;
            idx_q   <= dec_idx;
            cnt     <= '0;
            if (dec_mapped) begin
              req_q <= ONE_HOT0 << dec_idx;
              state <= WAIT;
            end else begin
              rdata_q  <= '0;
              err_q    <= 1'b1;
              rvalid_q <= 1'b1;
              state    <= RESP;
            end
          end
        end
        WAIT: begin
          if (ack_sel) begin
            req_q    <= '0;
            rdata_q  <= cap_rdata;
            err_q    <= 1'b0;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            req_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b1;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_ready  = (state == IDLE);
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_rdata  = rdata_q;
  assign bus.m_err    = err_q;
  assign bus.s_req    = req_q;
  assign bus.s_we     = we_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
endmodule
